// File: rtl/bnn_stream_loader.sv
// Byte-stream loader for the 4-neuron binarized MLP: loads input/weight/bias registers, runs, returns result byte.
// Optional BNN_LOADER_CHECKSUM_EN: each load is followed by an XOR checksum byte, and the commit happens only if it matches.
module bnn_stream_loader #(
  parameter int EVAL_CYCLES = 2,
  parameter int W_WIDTH     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [3:0]         mlp_input,
  output logic [W_WIDTH-1:0] mlp_weights,
  output logic [W_WIDTH-1:0] mlp_bias,
  input  logic [3:0]         mlp_result,
  output logic               busy,
  output logic               err
);

  localparam logic [7:0] CMD_IN  = 8'h01;
  localparam logic [7:0] CMD_WT  = 8'h02;
  localparam logic [7:0] CMD_BS  = 8'h03;
  localparam logic [7:0] CMD_RUN = 8'h04;
  localparam logic [7:0] EVAL_LAST = 8'(EVAL_CYCLES);

  typedef enum logic [1:0] {T_IN, T_WT, T_BS} tgt_t;

  typedef struct packed {
    tgt_t       tgt;
    logic [7:0] need;
  } cmd_t;

`ifdef BNN_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_EVAL, S_SEND} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_EVAL, S_SEND} state_t;
`endif

  state_t             state, state_nx;
  cmd_t               cur, dec;
  logic [7:0]         cnt;
  logic [7:0]         csum;
  logic [W_WIDTH-1:0] shadow;
  logic [W_WIDTH-1:0] shift_nx;
  logic [W_WIDTH-1:0] commit_word;
  logic               take, is_load, last, commit, bad, eval_done;

  assign take     = rx_valid && rx_ready;
  assign shift_nx = {shadow[W_WIDTH-9:0], rx_data};
  assign last     = (cnt == cur.need - 8'd1);
  assign busy     = (state != S_IDLE);

`ifdef BNN_LOADER_CHECKSUM_EN
  assign rx_ready    = !rst && (state == S_IDLE || state == S_PAYLOAD || state == S_CHECK);
  assign commit_word = shadow;
`else
  assign rx_ready    = !rst && (state == S_IDLE || state == S_PAYLOAD);
  assign commit_word = shift_nx;
`endif

  always_comb begin
    is_load = 1'b0;
    dec     = '{tgt: T_IN, need: 8'd1};
    case (rx_data)
      CMD_IN:  begin is_load = 1'b1; dec = '{tgt: T_IN, need: 8'd1}; end
      CMD_WT:  begin is_load = 1'b1; dec = '{tgt: T_WT, need: 8'd2}; end
      CMD_BS:  begin is_load = 1'b1; dec = '{tgt: T_BS, need: 8'd2}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    commit    = 1'b0;
    bad       = 1'b0;
    eval_done = 1'b0;
    case (state)
      S_IDLE:
        if (take) begin
          if (is_load)                state_nx = S_PAYLOAD;
          else if (rx_data == CMD_RUN) state_nx = S_EVAL;
          else                         bad      = 1'b1;
        end
      S_PAYLOAD:
        if (take && last) begin
`ifdef BNN_LOADER_CHECKSUM_EN
          state_nx = S_CHECK;
`else
          commit   = 1'b1;
          state_nx = S_IDLE;
`endif
        end
`ifdef BNN_LOADER_CHECKSUM_EN
      S_CHECK:
        if (take) begin
          if (rx_data == csum) commit = 1'b1;
          else                 bad    = 1'b1;
          state_nx = S_IDLE;
        end
`endif
      // First EVAL cycle lets the freshly held mlp_* values propagate; sampling lands EVAL_CYCLES later.
      S_EVAL:
        if (cnt == EVAL_LAST) begin
          eval_done = 1'b1;
          state_nx  = S_SEND;
        end
      S_SEND:
        if (tx_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= '{tgt: T_IN, need: 8'd1};
      cnt         <= '0;
      csum        <= '0;
      shadow      <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      mlp_input   <= '0;
      mlp_weights <= '0;
      mlp_bias    <= '0;
      err         <= 1'b0;
    end else begin
      err <= bad;
      case (state)
        S_IDLE:
          if (take) begin
            cnt <= '0;
            if (is_load) begin
              cur    <= dec;
              csum   <= rx_data;
              shadow <= '0;
            end
          end
        S_PAYLOAD:
          if (take) begin
            shadow <= shift_nx;
            csum   <= csum ^ rx_data;
            cnt    <= cnt + 8'd1;
          end
        S_EVAL:
          cnt <= cnt + 8'd1;
        S_SEND:
          if (tx_ready) tx_valid <= 1'b0;
        default: ;
      endcase
      if (eval_done) begin
        tx_data  <= {4'h0, mlp_result};
        tx_valid <= 1'b1;
      end
      // Targets change only here, so a partial payload is never visible.
      if (commit) begin
        case (cur.tgt)
          T_IN:    mlp_input   <= commit_word[3:0];
          T_WT:    mlp_weights <= commit_word;
          T_BS:    mlp_bias    <= commit_word;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bnn_stream_loader.sv
// Directed bench for bnn_stream_loader; tx results are checked against a scoreboard queue by a monitor.
module tb_bnn_stream_loader;
  localparam int EVAL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  mlp_input;
  logic [15:0] mlp_weights;
  logic [15:0] mlp_bias;
  logic [3:0]  mlp_result;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  bnn_stream_loader #(.EVAL_CYCLES(EVAL_CYCLES), .W_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mlp_input(mlp_input), .mlp_weights(mlp_weights), .mlp_bias(mlp_bias),
    .mlp_result(mlp_result), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: every accepted tx byte must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (sb.size() == 0) timeout("tx_unexpected");
      else chk("tx_data", {24'h0, tx_data}, {24'h0, sb.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!rx_ready) timeout("rx_stall");
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] c, input logic [7:0] b0, input logic [7:0] b1, input int n);
    send_byte(c);
    send_byte(b0);
    if (n == 2) send_byte(b1);
`ifdef BNN_LOADER_CHECKSUM_EN
    send_byte(c ^ b0 ^ ((n == 2) ? b1 : 8'h00));
`endif
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!tx_valid && n < 100);
    if (!tx_valid) timeout("wait_tx");
  endtask

  initial begin
    int lat;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1; mlp_result = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", {31'h0, rx_ready}, 0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_regs", {12'h0, mlp_input, mlp_weights}, 0);
    chk("rst_bias", {16'h0, mlp_bias}, 0);
    @(negedge clk) rst = 1'b0;

    // Load and run
    load(8'h01, 8'h0A, 8'h00, 1);
    chk("load_input", {28'h0, mlp_input}, 32'hA);
    load(8'h02, 8'hF0, 8'hF0, 2);
    chk("load_weights", {16'h0, mlp_weights}, 32'hF0F0);
    load(8'h03, 8'h00, 8'h00, 2);
    chk("load_bias", {16'h0, mlp_bias}, 32'h0);
    mlp_result = 4'h5;
    sb.push_back(8'h05);
    send_byte(8'h04);
    chk("run_busy", {31'h0, busy}, 1);
    wait_tx(lat);
    chk("run_latency", lat, EVAL_CYCLES + 1);
    @(posedge clk); #1;
    chk("run_tx_clear", {31'h0, tx_valid}, 0);
    chk("run_idle", {31'h0, busy}, 0);

    // Atomic commit
    send_byte(8'h02);
    send_byte(8'h12);
    repeat (10) @(posedge clk);
    #1 chk("atomic_hold", {16'h0, mlp_weights}, 32'hF0F0);
    send_byte(8'h34);
`ifdef BNN_LOADER_CHECKSUM_EN
    chk("atomic_wait_cs", {16'h0, mlp_weights}, 32'hF0F0);
    send_byte(8'h24);
`endif
    chk("atomic_commit", {16'h0, mlp_weights}, 32'h1234);

    // Bad command
    send_byte(8'h07);
    chk("bad_err", {31'h0, err}, 1);
    chk("bad_busy", {31'h0, busy}, 0);
    @(posedge clk); #1;
    chk("bad_err_pulse", {31'h0, err}, 0);
    chk("bad_regs", {12'h0, mlp_input, mlp_weights}, 32'hA1234);
    load(8'h01, 8'h03, 8'h00, 1);
    chk("bad_then_load", {28'h0, mlp_input}, 32'h3);

    // Backpressure, with a load stalled behind the pending result
    tx_ready = 1'b0;
    mlp_result = 4'hA;
    sb.push_back(8'h0A);
    send_byte(8'h04);
    wait_tx(lat);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("bp_valid", {31'h0, tx_valid}, 1);
          chk("bp_data", {24'h0, tx_data}, 32'h0A);
          chk("bp_rx_ready", {31'h0, rx_ready}, 0);
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_done", {31'h0, tx_valid}, 0);
      end
      load(8'h01, 8'h0C, 8'h00, 1);
    join
    chk("bp_stalled_load", {28'h0, mlp_input}, 32'hC);
    chk("bp_sb_empty", sb.size(), 0);

    // Reset mid-payload
    load(8'h03, 8'h12, 8'h34, 2);
    chk("bias_load", {16'h0, mlp_bias}, 32'h1234);
    send_byte(8'h03);
    send_byte(8'hAB);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rstp_bias", {16'h0, mlp_bias}, 0);
    chk("rstp_busy", {31'h0, busy}, 0);
    chk("rstp_regs", {12'h0, mlp_input, mlp_weights}, 0);
    @(negedge clk) rst = 1'b0;

    // Reset during SEND
    tx_ready = 1'b0;
    mlp_result = 4'h7;
    send_byte(8'h04);
    wait_tx(lat);
    chk("rsts_data", {24'h0, tx_data}, 32'h07);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rsts_tx_valid", {31'h0, tx_valid}, 0);
    chk("rsts_busy", {31'h0, busy}, 0);
    @(negedge clk) begin rst = 1'b0; tx_ready = 1'b1; end

`ifdef BNN_LOADER_CHECKSUM_EN
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h04);
    chk("cs_match", {28'h0, mlp_input}, 32'h5);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'hFF);
    chk("cs_err", {31'h0, err}, 1);
    chk("cs_unchanged", {28'h0, mlp_input}, 32'h5);
    @(posedge clk); #1;
    chk("cs_err_pulse", {31'h0, err}, 0);
`endif

    repeat (5) @(posedge clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
